// File: rtl/common_types_pkg.sv
// common_types_pkg: shared types and constants for the board system controller.
package common_types_pkg;
  typedef enum logic [1:0] {HOLD, RUN, DEBOUNCE} rst_state_t;
  localparam int PWM_W = 8;
endpackage

// File: rtl/sys_ctrl_fpga_if.sv
// sys_ctrl_fpga_if: board-pin and core-status bundle of the system controller.
interface sys_ctrl_fpga_if #(
  parameter int NUM_ACT = 2
);
  logic               ext_rst_n_i;
  logic               ce_o;
  logic               sys_rst_o;
  logic [NUM_ACT-1:0] act_i;
  logic               halt_i;
  logic [NUM_ACT-1:0] act_led_o;
  logic               halt_led_o;
  modport master (
    output ext_rst_n_i, act_i, halt_i,
    input  ce_o, sys_rst_o, act_led_o, halt_led_o
  );
  modport slave (
    input  ext_rst_n_i, act_i, halt_i,
    output ce_o, sys_rst_o, act_led_o, halt_led_o
  );
endinterface

// File: rtl/led_stretch.sv
// led_stretch: retriggerable activity stretcher, LED lit for STRETCH cycles after the last event.
module led_stretch #(
  parameter int STRETCH = 2**20
) (
  input  logic clk,
  input  logic rst,
  input  logic evt_i,
  output logic led_o
);
  localparam int W = STRETCH > 1 ? $clog2(STRETCH) : 1;
  logic [W-1:0] r_cnt;
  logic         r_led;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else begin
      r_cnt <= evt_i ? W'(STRETCH - 1) : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
      r_led <= evt_i || r_cnt != '0;
    end
  end
  assign led_o = r_led;
endmodule

// File: rtl/sys_ctrl_fpga.sv
// sys_ctrl_fpga: clock-enable, conditioned system reset and status LEDs.
// Define LED_PWM_EN to dim all LEDs with an 8-bit PWM of duty LED_DUTY/256.
module sys_ctrl_fpga
  import common_types_pkg::*;
#(
  parameter int DIV      = 2,
  parameter int RST_HOLD = 1024,
  parameter int DEBOUNCE = 256,
  parameter int NUM_ACT  = 2,
  parameter int STRETCH  = 2**20,
  parameter int BLINK    = 2**23
`ifdef LED_PWM_EN
  , parameter int LED_DUTY = 64
`endif
) (
  input logic            clk,
  input logic            rst,
  sys_ctrl_fpga_if.slave bus
);
  localparam int CE_W   = DIV > 1 ? $clog2(DIV) : 1;
  localparam int RC_MAX = RST_HOLD > DEBOUNCE ? RST_HOLD : DEBOUNCE;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam int BL_W   = BLINK > 1 ? $clog2(BLINK) : 1;

  logic [CE_W-1:0] r_ce_cnt;
  logic            r_ce;
  logic            w_ce_wrap;
  assign w_ce_wrap = r_ce_cnt == CE_W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_cnt <= '0;
      r_ce     <= 1'b0;
    end else begin
      r_ce_cnt <= w_ce_wrap ? '0 : r_ce_cnt + 1'b1;
      r_ce     <= w_ce_wrap;
    end
  end

  logic [1:0] r_sync;
  logic       w_btn_s;
  always_ff @(posedge clk) r_sync <= rst ? 2'b00 : {r_sync[0], bus.ext_rst_n_i};
  assign w_btn_s = r_sync[1];

  rst_state_t      r_state, w_state_nxt;
  logic [RC_W-1:0] r_rcnt, w_rcnt_nxt;
  logic            r_sys_rst, w_sys_rst_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HOLD;
      r_rcnt    <= '0;
      r_sys_rst <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_sys_rst <= w_sys_rst_nxt;
    end
  end
  // One counter serves both the release hold-off and the press debounce.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt + 1'b1;
    case (r_state)
      HOLD:
        if (!w_btn_s) w_rcnt_nxt = '0;
        else if (r_rcnt == RC_W'(RST_HOLD - 1)) w_state_nxt = RUN;
      RUN: begin
        w_rcnt_nxt = '0;
        if (!w_btn_s) w_state_nxt = common_types_pkg::DEBOUNCE;
      end
      common_types_pkg::DEBOUNCE:
        if (w_btn_s) w_state_nxt = RUN;
        else if (r_rcnt == RC_W'(DEBOUNCE - 1)) begin
          w_state_nxt = HOLD;
          w_rcnt_nxt  = '0;
        end
      default: w_state_nxt = HOLD;
    endcase
  end
  always_comb w_sys_rst_nxt = w_state_nxt == HOLD;

  logic [NUM_ACT-1:0] w_act_led;
  for (genvar i = 0; i < NUM_ACT; i++) begin : g_act
    led_stretch #(.STRETCH(STRETCH)) u_stretch (
      .clk  (clk),
      .rst  (rst),
      .evt_i(bus.act_i[i]),
      .led_o(w_act_led[i])
    );
  end

  logic [BL_W-1:0] r_bl_cnt;
  logic            r_bl_act, r_halt_led, w_bl_wrap;
  assign w_bl_wrap = r_bl_cnt == BL_W'(BLINK - 1);
  // The first halted cycle only lights the LED; counting starts on the next one.
  always_ff @(posedge clk) begin
    if (rst || !bus.halt_i) begin
      r_bl_cnt   <= '0;
      r_bl_act   <= 1'b0;
      r_halt_led <= 1'b0;
    end else begin
      r_bl_act   <= 1'b1;
      r_bl_cnt   <= (!r_bl_act || w_bl_wrap) ? '0 : r_bl_cnt + 1'b1;
      r_halt_led <= !r_bl_act ? 1'b1 : (w_bl_wrap ? ~r_halt_led : r_halt_led);
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_pwm_on;
  always_ff @(posedge clk) r_pwm_cnt <= rst ? '0 : r_pwm_cnt + 1'b1;
  assign w_pwm_on       = int'(r_pwm_cnt) < LED_DUTY;
  assign bus.act_led_o  = w_act_led & {NUM_ACT{w_pwm_on}};
  assign bus.halt_led_o = r_halt_led & w_pwm_on;
`else
  assign bus.act_led_o  = w_act_led;
  assign bus.halt_led_o = r_halt_led;
`endif
  assign bus.ce_o      = r_ce;
  assign bus.sys_rst_o = r_sys_rst;
endmodule

// File: tb/tb_sys_ctrl_fpga.sv
// tb_sys_ctrl_fpga: directed checks of clock enable, reset conditioning and LED stretch/blink.
module tb_sys_ctrl_fpga;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sys_ctrl_fpga_if #(.NUM_ACT(2)) if_a ();
  sys_ctrl_fpga_if #(.NUM_ACT(2)) if_b ();

  sys_ctrl_fpga #(.DIV(3), .RST_HOLD(8), .DEBOUNCE(4), .NUM_ACT(2), .STRETCH(5), .BLINK(4)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  sys_ctrl_fpga #(.DIV(1), .RST_HOLD(8), .DEBOUNCE(4), .NUM_ACT(2), .STRETCH(5), .BLINK(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    if_a.ext_rst_n_i = 1'b1;
    if_a.act_i = 2'b00;
    if_a.halt_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (if_a.ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", if_a.ce_o); end
    checks++; if (if_a.sys_rst_o !== 1'b1) begin errors++; $display("FAIL reset_sys_rst got %b exp 1", if_a.sys_rst_o); end
    checks++; if (if_a.act_led_o !== 2'b00) begin errors++; $display("FAIL reset_act_led got %b exp 00", if_a.act_led_o); end
    checks++; if (if_a.halt_led_o !== 1'b0) begin errors++; $display("FAIL reset_halt_led got %b exp 0", if_a.halt_led_o); end
    checks++; if (if_b.ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce_div1 got %b exp 0", if_b.ce_o); end
  endtask

  task automatic test_ce();
    do_reset();
    for (int n = 1; n <= 9; n++) begin
      step();
      checks++;
      if (if_a.ce_o !== (n % 3 == 0)) begin errors++; $display("FAIL ce_div3 edge %0d got %b exp %b", n, if_a.ce_o, n % 3 == 0); end
      checks++;
      if (if_b.ce_o !== 1'b1) begin errors++; $display("FAIL ce_div1 edge %0d got %b exp 1", n, if_b.ce_o); end
    end
  endtask

  task automatic test_hold();
    if_a.ext_rst_n_i = 1'b1;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      step();
      checks++;
      if (if_a.sys_rst_o !== (n < 10)) begin errors++; $display("FAIL hold edge %0d got %b exp %b", n, if_a.sys_rst_o, n < 10); end
    end
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      if_a.ext_rst_n_i = (n != 5);
      step();
      checks++;
      if (if_a.sys_rst_o !== (n < 15)) begin errors++; $display("FAIL hold_restart edge %0d got %b exp %b", n, if_a.sys_rst_o, n < 15); end
    end
    if_a.ext_rst_n_i = 1'b1;
  endtask

  task automatic test_debounce();
    for (int n = 1; n <= 10; n++) begin
      if_a.ext_rst_n_i = (n > 3);
      step();
      checks++;
      if (if_a.sys_rst_o !== 1'b0) begin errors++; $display("FAIL glitch edge %0d got %b exp 0", n, if_a.sys_rst_o); end
    end
    for (int n = 1; n <= 10; n++) begin
      if_a.ext_rst_n_i = 1'b0;
      step();
      checks++;
      if (if_a.sys_rst_o !== (n >= 7)) begin errors++; $display("FAIL debounce edge %0d got %b exp %b", n, if_a.sys_rst_o, n >= 7); end
    end
    for (int n = 1; n <= 12; n++) begin
      if_a.ext_rst_n_i = 1'b1;
      step();
      checks++;
      if (if_a.sys_rst_o !== (n < 10)) begin errors++; $display("FAIL rehold edge %0d got %b exp %b", n, if_a.sys_rst_o, n < 10); end
    end
  endtask

  task automatic test_stretch();
    logic [1:0] exp;
    for (int n = 1; n <= 8; n++) begin
      if_a.act_i = (n == 1) ? 2'b01 : 2'b00;
      step();
      exp = {1'b0, n <= 5};
      checks++;
      if (if_a.act_led_o !== exp) begin errors++; $display("FAIL stretch_single edge %0d got %b exp %b", n, if_a.act_led_o, exp); end
    end
    for (int n = 1; n <= 10; n++) begin
      if_a.act_i = (n == 1 || n == 4) ? 2'b01 : 2'b00;
      step();
      exp = {1'b0, n <= 8};
      checks++;
      if (if_a.act_led_o !== exp) begin errors++; $display("FAIL stretch_retrig edge %0d got %b exp %b", n, if_a.act_led_o, exp); end
    end
    for (int n = 1; n <= 11; n++) begin
      if_a.act_i = (n == 1 || n == 5) ? 2'b01 : 2'b00;
      step();
      exp = {1'b0, n <= 9};
      checks++;
      if (if_a.act_led_o !== exp) begin errors++; $display("FAIL stretch_expiry edge %0d got %b exp %b", n, if_a.act_led_o, exp); end
    end
    for (int n = 1; n <= 8; n++) begin
      if_a.act_i = (n <= 2) ? 2'b10 : 2'b00;
      step();
      exp = {n <= 6, 1'b0};
      checks++;
      if (if_a.act_led_o !== exp) begin errors++; $display("FAIL stretch_ch1 edge %0d got %b exp %b", n, if_a.act_led_o, exp); end
    end
  endtask

  task automatic test_halt();
    if_a.halt_i = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      checks++;
      if (if_a.halt_led_o !== (((n - 1) / 4) % 2 == 0)) begin
        errors++; $display("FAIL blink edge %0d got %b exp %b", n, if_a.halt_led_o, ((n - 1) / 4) % 2 == 0);
      end
    end
    if_a.halt_i = 1'b0;
    step();
    checks++; if (if_a.halt_led_o !== 1'b0) begin errors++; $display("FAIL blink_drop got %b exp 0", if_a.halt_led_o); end
    step();
    if_a.halt_i = 1'b1;
    step();
    checks++; if (if_a.halt_led_o !== 1'b1) begin errors++; $display("FAIL blink_restart got %b exp 1", if_a.halt_led_o); end
    step();
    if_a.halt_i = 1'b0;
    step();
    checks++; if (if_a.halt_led_o !== 1'b0) begin errors++; $display("FAIL blink_mid_drop got %b exp 0", if_a.halt_led_o); end
  endtask

  task automatic test_rst_mid();
    if_a.halt_i = 1'b1;
    if_a.act_i = 2'b01;
    repeat (3) step();
    checks++; if (if_a.act_led_o !== 2'b01) begin errors++; $display("FAIL pre_rst_led got %b exp 01", if_a.act_led_o); end
    checks++; if (if_a.sys_rst_o !== 1'b0) begin errors++; $display("FAIL pre_rst_sys_rst got %b exp 0", if_a.sys_rst_o); end
    rst = 1'b1;
    step();
    checks++; if (if_a.ce_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ce got %b exp 0", if_a.ce_o); end
    checks++; if (if_a.sys_rst_o !== 1'b1) begin errors++; $display("FAIL mid_rst_sys_rst got %b exp 1", if_a.sys_rst_o); end
    checks++; if (if_a.act_led_o !== 2'b00) begin errors++; $display("FAIL mid_rst_act_led got %b exp 00", if_a.act_led_o); end
    checks++; if (if_a.halt_led_o !== 1'b0) begin errors++; $display("FAIL mid_rst_halt_led got %b exp 0", if_a.halt_led_o); end
    rst = 1'b0;
    if_a.halt_i = 1'b0;
    if_a.act_i = 2'b00;
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int lit = 0;
    if_a.act_i = 2'b01;
    do_reset();
    repeat (4) step();
    for (int n = 0; n < 256; n++) begin
      step();
      lit += int'(if_a.act_led_o[0]);
    end
    checks++; if (lit !== 64) begin errors++; $display("FAIL pwm_duty got %0d exp 64", lit); end
    if_a.act_i = 2'b00;
  endtask
`endif

  initial begin
    if_b.ext_rst_n_i = 1'b1;
    if_b.act_i = 2'b00;
    if_b.halt_i = 1'b0;
    test_reset();
    test_ce();
    test_hold();
    test_debounce();
    test_stretch();
    test_halt();
    test_rst_mid();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
